pc_update: RTL and testbench

Sequential Y86-64 PC-update stage, directly downstream of writeback. Owns the architectural program counter and the processor status. Each accepted instruction's fetch/execute/memory results select the next PC. A two-state run/stop machine freezes the core on halt or on a fault. The `PC` output feeds fetch on the next cycle, replacing the testbench-driven `PC = valP` sequencing.

---
 rtl/pc_update.sv | 129 ++++++++++++
 tb/tb_pc_update.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_update.sv
// Y86-64 PC-update stage: owns the architectural PC, processor status and a RUN/STOP machine.
// Optional retired-instruction counter built when PC_UPDATE_RETIRE_CNT_EN is defined.
module pc_update #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ins_valid,
  input  logic [3:0]       icode,
  input  logic             cond,
  input  logic [63:0]      valC,
  input  logic [63:0]      valM,
  input  logic [63:0]      valP,
  input  logic             in_mem,
  input  logic             in_inst,
  input  logic             hlt,
  output logic [63:0]      PC,
  output logic [2:0]       stat,
  output logic             running,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned PC_W   = 64;
  localparam int unsigned STAT_W = 3;

  localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
  localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
  localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
  localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_STOP = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [STAT_W-1:0]   stat_q, stat_d;
  logic                running_q, running_d;
  logic                accept_c;
  logic                stop_c;

  // An instruction is only acted on while running; STOP ignores everything.
  assign accept_c = ins_valid && (state_q == S_RUN);
  assign stop_c   = in_inst || in_mem || hlt || (icode == I_HALT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: STOP is sticky until reset
  always_comb begin
    state_d = state_q;
    if (accept_c && stop_c) begin
      state_d = S_STOP;
    end
  end

  // Output logic: next PC / status; faults keep PC on the offending instruction
  always_comb begin
    pc_d      = pc_q;
    stat_d    = stat_q;
    running_d = (state_d == S_RUN);
    if (accept_c) begin
      if (in_inst) begin
        stat_d = STAT_INS;
      end else if (in_mem) begin
        stat_d = STAT_ADR;
      end else if (hlt || (icode == I_HALT)) begin
        stat_d = STAT_HLT;
      end else begin
        case (icode)
          I_CALL:  pc_d = valC;
          I_JXX:   pc_d = cond ? valC : valP;
          I_RET:   pc_d = valM;
          default: pc_d = valP;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      stat_q    <= STAT_AOK;
      running_q <= 1'b1;
    end else begin
      pc_q      <= pc_d;
      stat_q    <= stat_d;
      running_q <= running_d;
    end
  end

  assign PC      = pc_q;
  assign stat    = stat_q;
  assign running = running_q;

`ifdef PC_UPDATE_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             retire_c;

  // Halts and faults never retire; the count saturates instead of wrapping.
  assign retire_c = accept_c && !stop_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (retire_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign retired = cnt_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_pc_update.sv
// Randomized self-checking bench for pc_update with a behavioural model of the PC/status rules.
// Two instances share stimulus: default counter width and a 2-bit counter for saturation.
module tb_pc_update;

`ifdef PC_UPDATE_RETIRE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ins_valid = 1'b0;
  logic [3:0]  icode = 4'h1;
  logic        cond = 1'b0;
  logic [63:0] valC = '0, valM = '0, valP = '0;
  logic        in_mem = 1'b0, in_inst = 1'b0, hlt = 1'b0;

  logic [63:0] PC, PC2;
  logic [2:0]  stat, stat2;
  logic        running, running2;
  logic [31:0] retired;
  logic [1:0]  retired2;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state
  logic [63:0] m_pc;
  int          m_stat;
  bit          m_run;
  longint      m_cnt;

  pc_update #(.RESET_PC(64'd0), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .icode(icode), .cond(cond),
    .valC(valC), .valM(valM), .valP(valP), .in_mem(in_mem), .in_inst(in_inst), .hlt(hlt),
    .PC(PC), .stat(stat), .running(running), .retired(retired)
  );

  pc_update #(.RESET_PC(64'd0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ins_valid(ins_valid), .icode(icode), .cond(cond),
    .valC(valC), .valM(valM), .valP(valP), .in_mem(in_mem), .in_inst(in_inst), .hlt(hlt),
    .PC(PC2), .stat(stat2), .running(running2), .retired(retired2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_reset();
    m_pc = 64'd0; m_stat = 1; m_run = 1'b1; m_cnt = 0;
  endtask

  // Architectural rules: faults/halt freeze PC and stop; otherwise pick the next PC.
  task automatic model_apply();
    if (!ins_valid || !m_run) return;
    if (in_inst) begin
      m_stat = 4; m_run = 1'b0;
    end else if (in_mem) begin
      m_stat = 3; m_run = 1'b0;
    end else if (hlt || icode == 4'h0) begin
      m_stat = 2; m_run = 1'b0;
    end else begin
      if (icode == 4'h8 || (icode == 4'h7 && cond)) m_pc = valC;
      else if (icode == 4'h9) m_pc = valM;
      else m_pc = valP;
      m_cnt++;
    end
  endtask

  task automatic check_all();
    longint e1, e2;
    e1 = CNT_EN ? sat(m_cnt, 64'(32'hFFFF_FFFF)) : 0;
    e2 = CNT_EN ? sat(m_cnt, 3) : 0;
    chk("pc", PC, m_pc);
    chk("stat", 64'(stat), 64'(m_stat));
    chk("running", 64'(running), 64'(m_run));
    chk("retired", 64'(retired), 64'(e1));
    chk("pc_w2", PC2, m_pc);
    chk("stat_w2", 64'(stat2), 64'(m_stat));
    chk("retired_w2", 64'(retired2), 64'(e2));
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) check_all();
  end

  task automatic step(input logic v, input logic [3:0] ic, input logic c,
                      input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp,
                      input logic im, input logic ii, input logic h);
    ins_valid = v; icode = ic; cond = c; valC = vc; valM = vm; valP = vp;
    in_mem = im; in_inst = ii; hlt = h;
    @(posedge clk);
    model_apply();
    #1;
    ins_valid = 1'b0;
  endtask

  // Mid-cycle asynchronous reset, then release away from any edge
  task automatic do_reset(input bit pin);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    if (pin) begin
      chk("lit_rst_pc", PC, 64'd0);
      chk("lit_rst_stat", 64'(stat), 64'd1);
      chk("lit_rst_run", 64'(running), 64'd1);
      chk("lit_rst_ret", 64'(retired), 64'd0);
    end
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("lit_por_pc", PC, 64'd0);
    chk("lit_por_stat", 64'(stat), 64'd1);
    chk("lit_por_run", 64'(running), 64'd1);
    chk_en = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b1;

    step(1, 4'h3, 0, 0, 0, 64'd10, 0, 0, 0);
    chk("lit_irmov_pc", PC, 64'd10);
    chk("lit_irmov_stat", 64'(stat), 64'd1);
    chk("lit_irmov_ret", 64'(retired), CNT_EN ? 64'd1 : 64'd0);
    step(1, 4'h7, 1, 64'h40, 0, 64'd9, 0, 0, 0);
    chk("lit_jxx_taken", PC, 64'h40);
    step(1, 4'h7, 0, 64'h40, 0, 64'd9, 0, 0, 0);
    chk("lit_jxx_not", PC, 64'd9);
    step(1, 4'h8, 0, 64'h80, 0, 64'd18, 0, 0, 0);
    chk("lit_call", PC, 64'h80);
    step(1, 4'h9, 0, 64'h55, 64'h1A, 64'h81, 0, 0, 0);
    chk("lit_ret", PC, 64'h1A);

    step(1, 4'h1, 0, 0, 0, 64'h20, 0, 0, 0);
    step(1, 4'h1, 0, 0, 0, 64'h21, 1, 1, 0);
    chk("lit_ins_stat", 64'(stat), 64'd4);
    chk("lit_ins_run", 64'(running), 64'd0);
    chk("lit_ins_pc", PC, 64'h20);
    for (int i = 0; i < 3; i++) step(1, 4'h1, 0, 0, 0, 64'h99, 0, 0, 0);
    chk("lit_sticky_pc", PC, 64'h20);
    chk("lit_sticky_stat", 64'(stat), 64'd4);

    do_reset(1'b1);
    step(1, 4'h1, 0, 0, 0, 64'h30, 0, 0, 0);
    step(1, 4'h0, 0, 0, 0, 64'h31, 0, 0, 0);
    chk("lit_halt_stat", 64'(stat), 64'd2);
    chk("lit_halt_pc", PC, 64'h30);
    chk("lit_halt_ret", 64'(retired), CNT_EN ? 64'd1 : 64'd0);

    for (int i = 0; i < 5; i++)
      step(0, 4'($urandom), 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
           {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'($urandom));
    chk("lit_idle_pc", PC, 64'h30);
    chk("lit_idle_stat", 64'(stat), 64'd2);
    do_reset(1'b1);

    step(1, 4'h1, 0, 0, 0, 64'h5, 1, 0, 1);
    chk("lit_adr_over_hlt", 64'(stat), 64'd3);
    do_reset(1'b0);

    for (int i = 0; i < 5; i++) step(1, 4'h1, 0, 0, 0, 64'(2 * i + 2), 0, 0, 0);
    chk("lit_sat_w2", 64'(retired2), CNT_EN ? 64'd3 : 64'd0);
    chk("lit_nop_pc", PC, 64'd10);

    // Randomized run: mostly legal instructions, occasional faults/halts, reset after stop
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] ic;
      int r;
      logic [63:0] vp;
      r  = int'($urandom_range(0, 99));
      ic = 4'($urandom_range(1, 11));
      if (r < 3) ic = 4'h0;
      vp = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom};
      step(1'($urandom_range(0, 3) != 0), ic, 1'($urandom), {$urandom, $urandom},
           {$urandom, $urandom}, vp, r >= 3 && r < 5, r >= 5 && r < 7, r >= 7 && r < 9);
      if (!m_run && $urandom_range(0, 3) == 0) do_reset(1'b0);
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
